uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver; consumes the line driven by uart_transmitter.bit_out.
//  Frame: 1 start (0), 8 data LSB-first, 1 stop (1); line idles high.
//  Synchronises the line, detects the start edge and samples each bit mid-period.
//  Presents the received byte with a one-cycle valid pulse and flags framing errors.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per serial bit; legal range >=1; HALF = CLKS_PER_BIT/2 (integer division)
//  SYNC_STAGES   2  flops in the bit_in synchroniser; legal range >=1
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  bit_in     in   1  serial line, idle high
//  data_out   out  8  last correctly framed byte; holds until the next good frame
//  valid      out  1  one-cycle pulse; data_out is new in the same cycle
//  frame_err  out  1  one-cycle pulse; stop bit sampled 0
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  - Reset: data_out=0, valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
//    Synchroniser flops reset to 1, so reset never produces a false start.
//  - rxd is the output of the last synchroniser flop; the FSM sees only rxd.
//  - Cycle counter cnt: 0..CLKS_PER_BIT-1; bit index idx: 0..7.
//  - IDLE: on rxd==0 -> START, cnt=0.
//  - START: when cnt==HALF, re-sample rxd:
//    0 -> DATA, cnt=0, idx=0; 1 -> IDLE (glitch; no pulse of any kind).
//    With CLKS_PER_BIT=1, HALF=0: the check happens on the first START cycle.
//  - DATA: when cnt==CLKS_PER_BIT-1, shift rxd into shift_reg[idx] (LSB first) and reset cnt.
//    idx==7 -> STOP; otherwise idx++.
//  - STOP: when cnt==CLKS_PER_BIT-1, sample rxd:
//    1 -> data_out<=shift_reg, valid=1 for one cycle, then IDLE;
//    0 -> frame_err=1 for one cycle, data_out unchanged, then WAIT_HIGH.
//  - WAIT_HIGH: stays until rxd==1, then IDLE; a held-low line (break) yields exactly one frame_err.
//  - Timing: valid/frame_err assert 9*CLKS_PER_BIT+HALF+1 cycles after the first cycle in START.
//    Total latency from the bit_in falling edge adds SYNC_STAGES.
//  - Back-to-back: IDLE is re-entered one cycle after valid; a start bit that immediately
//    follows the stop bit must be accepted; no frame is dropped at line rate.
//  - valid and frame_err are never high together; each is high for exactly one cycle.
//  - rst mid-frame: immediate return to reset values; the partial byte is discarded, no pulse.
//  - Counter widths: $clog2(CLKS_PER_BIT) bits, minimum 1; no wrap beyond CLKS_PER_BIT-1.
// TESTING
//  1. Reset: rst=1 for 2 clk with bit_in=1 -> data_out=0, valid=0, frame_err=0, busy=0.
//  2. CLKS_PER_BIT=4: drive frame 0x65 (8'b01100101) -> one valid pulse, data_out=8'h65, busy falls.
//  3. Back-to-back frames 0x65 then 0x3E, no idle gap -> two valid pulses; data_out=8'h65, then 8'h3E.
//  4. bit_in low for 1 clk, then high -> busy pulses, no valid/frame_err, data_out unchanged.
//  5. Frame 0xA5 with stop bit=0, line then held low 40 clk -> one frame_err, no valid,
//     data_out unchanged, busy until line high.
//  6. rst pulsed after the 4th data bit of 0x3E -> outputs at reset values; the next frame 0x81
//     is received correctly. Repeat test 2 with CLKS_PER_BIT=1 looped back from uart_transmitter.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver, mid-bit sampling.
// Ports: clk, rst (sync, active high), bit_in (idle high),
//        data_out (last good byte), valid / frame_err (1-cycle
//        pulses), busy (FSM not idle).
module uart_receiver #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                 state_q, state_d, cur;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  assign rxd = sync_q[SYNC_STAGES-1];

  // The first cycle rxd is seen low already counts as START
  // (cnt=0), so HALF=0 checks the start bit in that same cycle
  // and every later sample lands HALF cycles into its bit.
  assign cur = (state_q == IDLE && !rxd) ? START : state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q[0] <= bit_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (cur)
      IDLE: begin
        cnt_d = '0;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = rxd ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rxd) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    data_d  = data_q;
    if (cur == STOP && cnt_q == LAST) begin
      if (rxd) begin
        valid_d = 1'b1;
        data_d  = shift_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign busy      = (cur != IDLE);
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: drives framed bytes into two receivers
// (4 and 1 clk per bit) and scores them against expected events.
module tb_uart_receiver;

  localparam int S     = 2;
  localparam int CPB4  = 4;
  localparam int HALF4 = CPB4 / 2;
  localparam int LAT4  = S + 9 * CPB4 + HALF4 + 1;
  localparam int LAT1  = S + 9 * 1 + 0 + 1;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line4 = 1'b1;
  logic       line1 = 1'b1;
  logic [7:0] data4, data1;
  logic       valid4, valid1;
  logic       ferr4, ferr1;
  logic       busy4, busy1;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        exp4[$];
  ev_t        exp1[$];
  logic [7:0] last4 = 8'h00;
  logic [7:0] last1 = 8'h00;
  bit         prev_bad;
  bit         saw_busy;

  uart_receiver #(.CLKS_PER_BIT(CPB4), .SYNC_STAGES(S)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (line4),
    .data_out  (data4),
    .valid     (valid4),
    .frame_err (ferr4),
    .busy      (busy4)
  );

  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(S)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (line1),
    .data_out  (data1),
    .valid     (valid1),
    .frame_err (ferr1),
    .busy      (busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 1) line1 = v;
    else line4 = v;
  endtask

  // Serial line model: start, 8 data LSB first, stop.
  task automatic send(input int which,
                      input logic [7:0] b,
                      input bit stop);
    int  cpb;
    ev_t e;
    cpb   = (which == 1) ? 1 : CPB4;
    e.err = !stop;
    e.d   = b;
    e.cyc = cyc + ((which == 1) ? LAT1 : LAT4);
    if (which == 1) exp1.push_back(e);
    else exp4.push_back(e);
    set_line(which, 1'b0);
    repeat (cpb) step();
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      repeat (cpb) step();
    end
    set_line(which, stop);
    repeat (cpb) step();
  endtask

  task automatic observe(input int which,
                         input logic v,
                         input logic fe,
                         input logic [7:0] d);
    ev_t e;
    int  n;
    if (v || fe) begin
      check($sformatf("excl%0d", which), 32'(v & fe), 0);
      n = (which == 1) ? exp1.size() : exp4.size();
      if (n == 0) begin
        check($sformatf("spurious%0d", which), n, 1);
      end else begin
        if (which == 1) e = exp1.pop_front();
        else e = exp4.pop_front();
        check($sformatf("kind%0d", which), 32'(fe), 32'(e.err));
        check($sformatf("when%0d", which), cyc, e.cyc);
        if (!e.err) begin
          if (which == 1) last1 = e.d;
          else last4 = e.d;
        end
      end
    end
    check($sformatf("data%0d", which), d,
          (which == 1) ? last1 : last4);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      observe(4, valid4, ferr4, data4);
      observe(1, valid1, ferr1, data1);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) step();
    check("rst_data", data4, 8'h00);
    check("rst_valid", 32'(valid4), 0);
    check("rst_ferr", 32'(ferr4), 0);
    check("rst_busy", 32'(busy4), 0);
    check("rst_busy1", 32'(busy1), 0);
    rst = 1'b0;
    repeat (4) step();

    send(4, 8'h65, 1'b1);
    repeat (12) step();
    check("t2_data", data4, 8'h65);
    check("t2_busy", 32'(busy4), 0);
    check("t2_pend", exp4.size(), 0);

    send(4, 8'h65, 1'b1);
    send(4, 8'h3E, 1'b1);
    repeat (12) step();
    check("t3_data", data4, 8'h3E);
    check("t3_pend", exp4.size(), 0);

    saw_busy = 1'b0;
    line4 = 1'b0;
    step();
    line4 = 1'b1;
    repeat (10) begin
      step();
      saw_busy |= busy4;
    end
    check("t4_busy_seen", 32'(saw_busy), 1);
    check("t4_busy_end", 32'(busy4), 0);
    check("t4_data", data4, 8'h3E);

    send(4, 8'hA5, 1'b0);
    repeat (40) step();
    check("t5_busy_low", 32'(busy4), 1);
    line4 = 1'b1;
    repeat (4) step();
    check("t5_busy_high", 32'(busy4), 0);
    check("t5_data", data4, 8'h3E);
    check("t5_pend", exp4.size(), 0);

    line4 = 1'b0;
    repeat (CPB4) step();
    for (int i = 0; i < 4; i++) begin
      line4 = (8'h3E >> i) & 8'h01;
      repeat (CPB4) step();
    end
    rst = 1'b1;
    line4 = 1'b1;
    step();
    last4 = 8'h00;
    last1 = 8'h00;
    rst = 1'b0;
    check("t6_data", data4, 8'h00);
    check("t6_valid", 32'(valid4), 0);
    check("t6_ferr", 32'(ferr4), 0);
    check("t6_busy", 32'(busy4), 0);
    repeat (8) step();
    send(4, 8'h81, 1'b1);
    repeat (12) step();
    check("t6_next", data4, 8'h81);

    send(1, 8'h65, 1'b1);
    repeat (4) step();
    check("t7_data", data1, 8'h65);
    check("t7_busy", 32'(busy1), 0);
    send(1, 8'h65, 1'b1);
    send(1, 8'h3E, 1'b1);
    repeat (4) step();
    check("t7_b2b", data1, 8'h3E);

    prev_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (prev_bad) begin
        repeat ($urandom_range(0, 10)) step();
        line4 = 1'b1;
        repeat (CPB4) step();
      end
      if ($urandom_range(0, 5) == 0) begin
        line4 = 1'b0;
        repeat ($urandom_range(1, HALF4)) step();
        line4 = 1'b1;
        repeat (2 * CPB4) step();
      end
      repeat ($urandom_range(0, 2 * CPB4)) step();
      prev_bad = ($urandom_range(0, 4) == 0);
      send(4, 8'($urandom), !prev_bad);
    end
    line4 = 1'b1;

    prev_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (prev_bad) begin
        repeat ($urandom_range(0, 5)) step();
        line1 = 1'b1;
        step();
      end
      repeat ($urandom_range(0, 2)) step();
      prev_bad = ($urandom_range(0, 4) == 0);
      send(1, 8'($urandom), !prev_bad);
    end
    line1 = 1'b1;

    repeat (60) step();
    check("end_pend4", exp4.size(), 0);
    check("end_pend1", exp1.size(), 0);
    check("end_busy4", 32'(busy4), 0);
    check("end_busy1", 32'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
